// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns single valid/ready requests into APB transfers.
// One transfer in flight; ACCESS phase is bounded by a timeout abort.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Only an idle, out-of-reset bridge takes a new request.
    assign req_ready = (state == IDLE) && !PRESET;

    // Transfer sequencer: APB phases, timeout counter and response hold.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    PENABLE <= 1'b0;
                    if (req_valid) begin
                        PWRITE <= req_write;
                        PADDR  <= req_addr;
                        PWDATA <= req_wdata;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end else begin
                        PSEL <= 1'b0;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave beats a timeout landing in the same cycle.
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else if (cnt == CNT_MAX) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB requester bridge
// against a small APB memory model with configurable wait states.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int checks = 0;
    int errors = 0;

    // slave model: PREADY in ACCESS cycle (slave_wait+1); hang never answers
    int          slave_wait = 2;
    logic        hang = 1'b0;
    int          wcnt = 0;
    logic [31:0] mem [0:63];

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY)
    );

    assign PREADY = PSEL && PENABLE && !hang && (wcnt == slave_wait);
    assign PRDATA = PREADY ? mem[PADDR[7:2]] : 32'hBADC0FFE;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[7:2]] <= PWDATA;
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    end

    // Drives one request from a negedge; reports latency (cycles counted
    // from the handshake cycle to the cycle rsp_valid is seen), ACCESS
    // cycle count and protocol deviations. Leaves rsp_valid pending.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int acc, output int bad);
        bad = 0;
        acc = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        if (!req_ready) bad++;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
        lat = 1;
        if (!(PSEL && !PENABLE && PADDR == a && PWRITE == w)) bad++;
        if (w && PWDATA != d) bad++;
        while (lat < 100) begin
            @(negedge PCLK);
            lat++;
            if (rsp_valid) begin
                if (PSEL || PENABLE) bad++;
                break;
            end
            if (!(PSEL && PENABLE && PADDR == a && PWRITE == w)) bad++;
            if (w && PWDATA != d) bad++;
            acc++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        repeat (2) @(negedge PCLK);
        checks++;
        if ({req_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {req_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
        end
        checks++;
        if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0", PADDR, PWDATA, rsp_rdata);
        end
        PRESET = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got ready=%b psel=%b want 1 0", req_ready, PSEL);
        end
        @(negedge PCLK);
    endtask

    task automatic test_write();
        int lat, acc, bad;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, lat, acc, bad);
        checks++;
        if (lat !== 5 || acc !== 3 || bad !== 0) begin
            errors++;
            $display("FAIL write_timing got lat=%0d acc=%0d bad=%0d want 5 3 0", lat, acc, bad);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp got %h err=%b want 0 0", rsp_rdata, rsp_err);
        end
        ack();
    endtask

    task automatic test_read();
        int lat, acc, bad;
        xfer(1'b0, 32'h10, 32'h0, lat, acc, bad);
        checks++;
        if (lat !== 5 || acc !== 3 || bad !== 0) begin
            errors++;
            $display("FAIL read_timing got lat=%0d acc=%0d bad=%0d want 5 3 0", lat, acc, bad);
        end
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp got %h err=%b want deadbeef 0", rsp_rdata, rsp_err);
        end
        ack();
    endtask

    task automatic test_timeout();
        int lat, acc, bad;
        hang = 1'b1;
        xfer(1'b0, 32'h10, 32'h0, lat, acc, bad);
        hang = 1'b0;
        checks++;
        if (acc !== 16 || lat !== 18 || bad !== 0) begin
            errors++;
            $display("FAIL timeout_timing got acc=%0d lat=%0d bad=%0d want 16 18 0", acc, lat, bad);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rsp got err=%b data=%h want 1 0", rsp_err, rsp_rdata);
        end
        ack();
        checks++;
        if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear got err=%b valid=%b want 0 0", rsp_err, rsp_valid);
        end
        xfer(1'b0, 32'h10, 32'h0, lat, acc, bad);
        checks++;
        if (lat !== 5 || bad !== 0 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL after_timeout got lat=%0d bad=%0d err=%b data=%h want 5 0 0 deadbeef",
                     lat, bad, rsp_err, rsp_rdata);
        end
        ack();
    endtask

    task automatic test_rsp_stall();
        int lat, acc, bad, held, n;
        xfer(1'b0, 32'h10, 32'h0, lat, acc, bad);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            if (rsp_valid && !rsp_err && rsp_rdata == 32'hDEADBEEF && !req_ready && !PSEL)
                held++;
        end
        checks++;
        if (held !== 4) begin
            errors++;
            $display("FAIL stall_hold got %0d good cycles want 4", held);
        end
        rsp_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got valid=%b ready=%b psel=%b want 0 1 0",
                     rsp_valid, req_ready, PSEL);
        end
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h30 || PWRITE !== 1'b1) begin
            errors++;
            $display("FAIL next_accept got psel=%b pen=%b addr=%h wr=%b want 1 0 30 1",
                     PSEL, PENABLE, PADDR, PWRITE);
        end
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL next_rsp got valid=%b err=%b data=%h want 1 0 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int lat, acc, bad, seen;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            errors++;
            $display("FAIL mid_access got psel=%b pen=%b want 1 1", PSEL, PENABLE);
        end
        #2 PRESET = 1'b1;
        #1;
        checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset got %b want 0000", {PSEL, PENABLE, rsp_valid, req_ready});
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abandoned got %0d active cycles want 0", seen);
        end
        xfer(1'b1, 32'h20, 32'hCAFEF00D, lat, acc, bad);
        checks++;
        if (lat !== 5 || bad !== 0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_write got lat=%0d bad=%0d err=%b want 5 0 0", lat, bad, rsp_err);
        end
        ack();
        xfer(1'b0, 32'h20, 32'h0, lat, acc, bad);
        checks++;
        if (rsp_rdata !== 32'hCAFEF00D || bad !== 0) begin
            errors++;
            $display("FAIL post_reset_read got %h bad=%0d want cafef00d 0", rsp_rdata, bad);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int lat, acc, bad;
        slave_wait = 0;
        xfer(1'b1, 32'h40, 32'hA5A55A5A, lat, acc, bad);
        checks++;
        if (lat !== 3 || acc !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL zero_wait_write got lat=%0d acc=%0d bad=%0d want 3 1 0", lat, acc, bad);
        end
        ack();
        xfer(1'b0, 32'h40, 32'h0, lat, acc, bad);
        checks++;
        if (lat !== 3 || rsp_rdata !== 32'hA5A55A5A || bad !== 0) begin
            errors++;
            $display("FAIL zero_wait_read got lat=%0d data=%h bad=%0d want 3 a5a55a5a 0",
                     lat, rsp_rdata, bad);
        end
        ack();
        slave_wait = 2;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_rsp_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
